// File: rtl/dmem_pkg.sv
// Shared state type and geometry helpers for the data memory system.
// Optional DMEM_STATS_EN adds hit/miss counters to the top.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        REFILL,
        WR_WAIT
    } dmem_state_t;

    function automatic int offset_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int index_w(input int cache_lines);
        return $clog2(cache_lines);
    endfunction

    function automatic int tag_w(
        input int addr_width,
        input int block_words,
        input int cache_lines
    );
        return addr_width - $clog2(block_words) - $clog2(cache_lines);
    endfunction

    function automatic int cnt_w(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/dmem_backing_store.sv
// Word-addressed main memory: combinational block read, clocked word write.
// Contents are deliberately not reset.
module dmem_backing_store
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                              clk,
    input  logic [ADDR_WIDTH-1:0]             blk_addr,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] blk_data,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data
);

    localparam int OFFSET_W = offset_w(BLOCK_WORDS);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // Gather every word of the addressed block.
    always_comb begin
        blk_data = '0;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            blk_data[w*DATA_WIDTH +: DATA_WIDTH] =
                mem[{blk_addr[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(w)}];
        end
    end

    // Single-word write-through port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/param_data_memory_system.sv
// Direct-mapped, write-through, no-write-allocate cache over main memory.
// Define DMEM_STATS_EN to add saturating HitCount/MissCount outputs.
module param_data_memory_system
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int BLOCK_WORDS  = 4,
    parameter int CACHE_LINES  = 32,
    parameter int MAIN_LATENCY = 4
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] WordAddress,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic                  Stall,
    output logic [DATA_WIDTH-1:0] DataOut
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]           HitCount,
    output logic [15:0]           MissCount
`endif
);

    localparam int OFFSET_W = offset_w(BLOCK_WORDS);
    localparam int INDEX_W  = index_w(CACHE_LINES);
    localparam int TAG_W    = tag_w(ADDR_WIDTH, BLOCK_WORDS, CACHE_LINES);
    localparam int CNT_W    = cnt_w(MAIN_LATENCY);
    localparam bit ONE_CYC  = (MAIN_LATENCY == 1);
    // The accepting IDLE cycle is latency cycle 0, so wait states cover the rest.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((MAIN_LATENCY >= 2) ? MAIN_LATENCY - 2 : 0);

    dmem_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [CACHE_LINES-1:0] valid;
    logic [TAG_W-1:0] tags [CACHE_LINES];
    logic [DATA_WIDTH-1:0] lines [CACHE_LINES][BLOCK_WORDS];
    logic [BLOCK_WORDS*DATA_WIDTH-1:0] blk_data;

    logic [TAG_W-1:0] in_tag, req_tag, c_tag;
    logic [INDEX_W-1:0] in_idx, req_idx, c_idx;
    logic [OFFSET_W-1:0] in_off, c_off;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic hit, rd_hit, rd_miss, wr_req, cnt_done, commit, refill;

    assign in_tag  = WordAddress[ADDR_WIDTH-1 -: TAG_W];
    assign in_idx  = WordAddress[OFFSET_W +: INDEX_W];
    assign in_off  = WordAddress[OFFSET_W-1:0];
    assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx = req_addr[OFFSET_W +: INDEX_W];

    assign hit      = valid[in_idx] && (tags[in_idx] == in_tag);
    assign rd_hit   = rst_n && state == IDLE && MemRead && !MemWrite && hit;
    assign rd_miss  = rst_n && state == IDLE && MemRead && !MemWrite && !hit;
    assign wr_req   = rst_n && state == IDLE && MemWrite;
    assign cnt_done = (cnt == CNT_LAST);
    assign refill   = (state == REFILL);
    assign commit   = (state == WR_WAIT && cnt_done) || (wr_req && ONE_CYC);

    // A single-cycle write commits straight from the request inputs.
    assign c_addr = (state == IDLE) ? WordAddress : req_addr;
    assign c_data = (state == IDLE) ? DataIn : req_data;
    assign c_tag  = c_addr[ADDR_WIDTH-1 -: TAG_W];
    assign c_idx  = c_addr[OFFSET_W +: INDEX_W];
    assign c_off  = c_addr[OFFSET_W-1:0];

    dmem_backing_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLOCK_WORDS(BLOCK_WORDS)
    ) u_store (
        .clk     (CLK),
        .blk_addr(req_addr),
        .blk_data(blk_data),
        .wr_en   (commit),
        .wr_addr (c_addr),
        .wr_data (c_data)
    );

    // Next-state and latency counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (MemWrite) begin
                    state_nxt = ONE_CYC ? IDLE : WR_WAIT;
                    cnt_nxt   = '0;
                end else if (MemRead && !hit) begin
                    state_nxt = ONE_CYC ? REFILL : RD_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RD_WAIT: begin
                if (cnt_done) state_nxt = REFILL;
                else          cnt_nxt   = cnt + 1'b1;
            end
            REFILL:  state_nxt = IDLE;
            WR_WAIT: begin
                if (cnt_done) state_nxt = IDLE;
                else          cnt_nxt   = cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Requestor-facing outputs; reset forces them quiet immediately.
    always_comb begin
        Stall   = rst_n && (state != IDLE || MemWrite || (MemRead && !hit));
        DataOut = rd_hit ? lines[in_idx][in_off] : '0;
    end

    // FSM, counter and valid bits.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (refill) valid[req_idx] <= 1'b1;
        end
    end

    // Capture the request while idle; reads keep only the block base.
    always_ff @(posedge CLK) begin
        if (state == IDLE) begin
            req_addr <= MemWrite ? WordAddress
                      : {WordAddress[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
            req_data <= DataIn;
        end
    end

    // Tag and data arrays: block refill, or word update on a write hit.
    always_ff @(posedge CLK) begin
        if (refill) begin
            tags[req_idx] <= req_tag;
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                lines[req_idx][w] <= blk_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (commit && valid[c_idx] && tags[c_idx] == c_tag) begin
            lines[c_idx][c_off] <= c_data;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating counts of idle read decisions.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            if (rd_hit && HitCount != 16'hFFFF)
                HitCount <= HitCount + 16'd1;
            if (rd_miss && MissCount != 16'hFFFF)
                MissCount <= MissCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_data_memory_system.sv
// Self-checking bench: directed table, reset corner, random traffic vs model.
// Define DMEM_STATS_EN to also check the hit/miss counters.
module tb_param_data_memory_system;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 4;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic MemRead = 1'b0;
    logic MemWrite = 1'b0;
    logic [AW-1:0] WordAddress = '0;
    logic [DW-1:0] DataIn = '0;
    logic Stall;
    logic [DW-1:0] DataOut;
`ifdef DMEM_STATS_EN
    logic [15:0] HitCount, MissCount;
`endif

    param_data_memory_system dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .WordAddress(WordAddress),
        .DataIn     (DataIn),
        .Stall      (Stall),
        .DataOut    (DataOut)
`ifdef DMEM_STATS_EN
        ,
        .HitCount   (HitCount),
        .MissCount  (MissCount)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail = 0;

    // Reference: flat memory plus which block each line currently holds.
    logic [DW-1:0] m_mem [1024];
    bit m_valid [32];
    logic [2:0] m_tag [32];
    int m_hits = 0;
    int m_misses = 0;

    typedef struct {
        bit rd;
        bit wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int st;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl [15];

    function automatic void check(input string name,
                                  input logic [31:0] got,
                                  input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    task automatic model(input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int st, output logic [DW-1:0] dout);
        int idx;
        logic [2:0] tg;
        idx = int'(a[6:2]);
        tg = a[9:7];
        st = 0;
        dout = '0;
        if (wr) begin
            st = LAT;
            m_mem[a] = d;
        end else if (rd) begin
            dout = m_mem[a];
            if (!(m_valid[idx] && m_tag[idx] == tg)) begin
                st = LAT + 1;
                m_valid[idx] = 1'b1;
                m_tag[idx] = tg;
                if (m_misses < 65535) m_misses++;
            end
            if (m_hits < 65535) m_hits++;
        end
    endtask

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    // One request; a write's inputs drop after acceptance since it is latched.
    task automatic xact(input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int st, output logic [DW-1:0] dout,
                        output bit zok);
        @(negedge CLK);
        MemRead = rd;
        MemWrite = wr;
        WordAddress = a;
        DataIn = d;
        st = 0;
        zok = 1'b1;
        for (int k = 0; k < 64; k++) begin
            #1;
            if (!Stall) break;
            st++;
            if (DataOut !== '0) zok = 1'b0;
            @(negedge CLK);
            if (wr) begin
                MemRead = 1'b0;
                MemWrite = 1'b0;
            end
        end
        dout = DataOut;
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic run_model(input string name, input bit rd, input bit wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        int est, st;
        logic [DW-1:0] edo, dout;
        bit zok;
        model(rd, wr, a, d, est, edo);
        xact(rd, wr, a, d, st, dout, zok);
        check({name, " stall"}, st, est);
        check({name, " data"}, dout, edo);
        check({name, " quiet"}, zok, 1);
    endtask

    initial begin
        int st, est;
        logic [DW-1:0] dout, edo;
        bit zok;

        tbl[0]  = '{0, 1, 10'h004, 32'hDEADBEEF, 4, 32'h0};
        tbl[1]  = '{1, 0, 10'h004, 32'h0, 5, 32'hDEADBEEF};
        tbl[2]  = '{1, 0, 10'h005, 32'h0, 0, 32'hF0000005};
        tbl[3]  = '{1, 0, 10'h010, 32'h0, 5, 32'hF0000010};
        tbl[4]  = '{0, 1, 10'h011, 32'h12345678, 4, 32'h0};
        tbl[5]  = '{1, 0, 10'h011, 32'h0, 0, 32'h12345678};
        tbl[6]  = '{0, 1, 10'h012, 32'h0BADF00D, 4, 32'h0};
        tbl[7]  = '{1, 0, 10'h012, 32'h0, 0, 32'h0BADF00D};
        tbl[8]  = '{1, 0, 10'h004, 32'h0, 0, 32'hDEADBEEF};
        tbl[9]  = '{1, 0, 10'h084, 32'h0, 5, 32'hF0000084};
        tbl[10] = '{1, 0, 10'h004, 32'h0, 5, 32'hDEADBEEF};
        tbl[11] = '{1, 1, 10'h030, 32'hA5A5A5A5, 4, 32'h0};
        tbl[12] = '{1, 0, 10'h030, 32'h0, 5, 32'hA5A5A5A5};
        tbl[13] = '{0, 0, 10'h030, 32'h0, 0, 32'h0};
        tbl[14] = '{1, 0, 10'h030, 32'h0, 0, 32'hA5A5A5A5};

        // Reset holds outputs quiet even with a request present.
        MemRead = 1'b1;
        WordAddress = 10'h123;
        repeat (2) @(posedge CLK);
        #1;
        check("reset stall", Stall, 0);
        check("reset data", DataOut, 0);
`ifdef DMEM_STATS_EN
        check("reset hits", HitCount, 0);
        check("reset misses", MissCount, 0);
`endif
        @(negedge CLK);
        rst_n = 1'b1;
        MemRead = 1'b0;
        #1;
        check("idle stall", Stall, 0);

        // Known contents everywhere; writes leave the cache empty.
        for (int a = 0; a < 1024; a++) begin
            model(0, 1, AW'(a), 32'hF0000000 | a, est, edo);
            xact(0, 1, AW'(a), 32'hF0000000 | a, st, dout, zok);
        end
        model_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            model(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, est, edo);
            xact(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, st, dout, zok);
            check($sformatf("vec%0d stall", i), st, tbl[i].st);
            check($sformatf("vec%0d data", i), dout, tbl[i].dout);
            check($sformatf("vec%0d quiet", i), zok, 1);
        end

        // Reset in the second wait cycle of a miss.
        @(negedge CLK);
        MemRead = 1'b1;
        WordAddress = 10'h020;
        #1;
        check("miss020 stall", Stall, 1);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        rst_n = 1'b0;
        #1;
        check("midreset stall", Stall, 0);
        check("midreset data", DataOut, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        MemRead = 1'b0;
        model_reset();
        run_model("post-reset 020", 1, 0, 10'h020, '0);
        run_model("post-reset 004", 1, 0, 10'h004, '0);

        // Random traffic concentrated on a few lines to force conflicts.
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            int op;
            a = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 2'($urandom)};
            op = $urandom_range(0, 3);
            run_model($sformatf("rnd%0d", n), op[0], op[1], a, $urandom);
        end
`ifdef DMEM_STATS_EN
        check("rnd hits", HitCount, 16'(m_hits));
        check("rnd misses", MissCount, 16'(m_misses));

        @(negedge CLK);
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        model_reset();
        run_model("st miss0", 1, 0, 10'h100, '0);
        run_model("st miss1", 1, 0, 10'h204, '0);
        run_model("st miss2", 1, 0, 10'h300, '0);
        run_model("st hit0", 1, 0, 10'h301, '0);
        run_model("st wr0", 0, 1, 10'h302, 32'h11111111);
        run_model("st hit1", 1, 0, 10'h205, '0);
        run_model("st wr1", 0, 1, 10'h040, 32'h22222222);
        check("stat hits", HitCount, 16'd5);
        check("stat misses", MissCount, 16'd3);

        @(negedge CLK);
        MemRead = 1'b1;
        WordAddress = 10'h300;
        repeat (65540) @(posedge CLK);
        @(negedge CLK);
        check("sat hits", HitCount, 16'hFFFF);
        check("sat misses", MissCount, 16'd3);
        MemRead = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
